inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter n, default 400: depth, in bytes, of the target instruction memory.
REQ-002 Parameter width, default 8: bits per memory byte and per stream byte.
REQ-003 Parameter pc, default 32: address and length width.
REQ-004 clk  input  1: the single clock; all state changes on the rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 start  input  1: request a load session; sampled only in IDLE.
REQ-007 byte_in  input  width: stream byte.
REQ-008 byte_valid  input  1: byte_in is valid.
REQ-009 byte_ready  output  1: loader accepts byte_in this cycle.
REQ-010 mem_we  output  1: write strobe to the instruction memory byte array.
REQ-011 mem_addr  output  pc: byte address for the write.
REQ-012 mem_wdata  output  width: byte to write.
REQ-013 busy  output  1: session in progress; processor held while high.
REQ-014 done  output  1: one-cycle pulse on successful completion.
REQ-015 err  output  1: sticky error flag.
REQ-016 byte_count  output  pc: number of bytes written in the current or last session, including fill bytes.

Function
REQ-017 A byte SHALL transfer on a rising edge where byte_valid and byte_ready are both high; at most one byte transfers per cycle.
REQ-018 States SHALL be IDLE, HDR, DATA, FILL, DONE.
REQ-019 IDLE: byte_ready=0 and bytes are ignored; start=1 -> HDR, and the same edge clears byte_count and err.
REQ-020 HDR: byte_ready=1; it accepts 4 bytes forming length L big-endian (first byte = L[31:24]).
REQ-021 After the 4th header byte: L>n or L[1:0]!=0 -> err=1 and the next state is IDLE (no done pulse); L=0 -> FILL; otherwise -> DATA.
REQ-022 DATA: byte_ready=1; the k-th accepted byte (k=0..L-1) SHALL be written to address k.
REQ-023 Write latency SHALL be 1 cycle: a byte accepted at edge t produces mem_we=1, mem_addr=k, mem_wdata=byte for the cycle following t (registered outputs).
REQ-024 byte_count SHALL increment on each write; after byte L-1 is accepted the next state is FILL.
REQ-025 FILL: byte_ready=0; one zero byte (nop) per cycle is written to addresses L..n-1 with the same 1-cycle registered timing; after address n-1 the next state is DONE; L=n writes no fill bytes.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 busy=1 in HDR, DATA, FILL and DONE; busy=0 in IDLE.
REQ-028 start asserted while busy SHALL be ignored.
REQ-029 Stalls (byte_valid=0) in HDR or DATA SHALL hold the state and counters indefinitely with no timeout.
REQ-030 mem_we=0 in every cycle not produced by REQ-023 or REQ-025; mem_addr never reaches n or above while mem_we=1.
REQ-031 Address and length arithmetic SHALL be unsigned, pc bits wide, with no wrap-around inside a session.

Reset
REQ-032 rst=1 at an edge: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, byte_count=0.
REQ-033 rst SHALL take priority over every other input, including mid-session; the aborted session produces no further writes and no done pulse.

Verification (bench with n=16)
REQ-034 start, then header 00 00 00 08 and bytes 11..18 with byte_valid held high -> writes addr 0..7 = 11..18, then addr 8..15 = 00, then done pulses once, byte_count=16.
REQ-035 Header 00 00 00 14 (L=20>16) -> err=1, no mem_we ever, no done pulse, return to IDLE; a following valid session clears err.
REQ-036 Header 00 00 00 06 -> err=1 (length not word-aligned), no writes.
REQ-037 Header 00 00 00 00 -> 16 zero writes to addr 0..15, then done.
REQ-038 Random byte_valid gaps in DATA plus start pulses while busy -> write sequence identical to the gap-free case; no second session starts.
REQ-039 rst asserted after the 3rd data byte -> the next cycle has mem_we=0 and all outputs at reset values; byte_valid is ignored until a new start.

Source files
------------

// File: rtl/inst_loader_if.sv
// Bundles the loader's stream input, memory write port and status signals.
// master: the side that drives the stream (testbench or boot source).
// slave: the loader itself.
interface inst_loader_if #(
    parameter int unsigned width = 8,
    parameter int unsigned pc    = 32
) ();
    logic             start;
    logic [width-1:0] byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             mem_we;
    logic [pc-1:0]    mem_addr;
    logic [width-1:0] mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [pc-1:0]    byte_count;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, byte_count
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, byte_count
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: receives a big-endian 4-byte length header followed by
// that many program bytes, writes them to instruction memory starting at
// address 0, then zero-fills the rest of the memory before pulsing done.
module inst_loader #(
    parameter int unsigned n     = 400,
    parameter int unsigned width = 8,
    parameter int unsigned pc    = 32
) (
    input logic          clk,
    input logic          rst,
    inst_loader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StFill, StDone} state_e;

    localparam logic [pc-1:0] NBytes = pc'(n);
    localparam logic [pc-1:0] One    = pc'(1);

    state_e           state_q, state_d;
    logic [1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [pc-1:0]    len_q, len_d;
    logic [pc-1:0]    addr_q, addr_d;    // next address to write
    logic [pc-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [pc-1:0]    waddr_q, waddr_d;
    logic [width-1:0] wdata_q, wdata_d;

    logic          byte_ready;
    logic          accept;
    logic [pc-1:0] len_shift;

    assign byte_ready = (state_q == StHdr) || (state_q == StData);
    assign accept     = byte_ready && bus.byte_valid;
    // Header bytes arrive MSB first, so each new byte shifts in at the bottom.
    assign len_shift  = (len_q << width) | pc'(bus.byte_in);

    // Next-state and registered write-port computation.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        count_d   = count_q;
        err_d     = err_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StHdr;
                    hdr_cnt_d = 2'd0;
                    len_d     = '0;
                    addr_d    = '0;
                    count_d   = '0;
                    err_d     = 1'b0;
                end
            end
            StHdr: begin
                if (accept) begin
                    len_d     = len_shift;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if ((len_shift > NBytes) || (len_shift[1:0] != 2'b00)) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else if (len_shift == '0) begin
                            state_d = StFill;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = bus.byte_in;
                    addr_d  = addr_q + One;
                    count_d = count_q + One;
                    if (addr_q + One == len_q) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                // A full-length program arrives here with addr_q == n: nothing to fill.
                if (addr_q >= NBytes) begin
                    state_d = StDone;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = '0;
                    addr_d  = addr_q + One;
                    count_d = count_q + One;
                    if (addr_q + One == NBytes) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hdr_cnt_q <= 2'd0;
            len_q     <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = err_q;
    assign bus.byte_count = count_q;

endmodule
